tm_load_sequencer: RTL and testbench

TM_LOAD_SEQUENCER -- requirements
Module: tm_load_sequencer

---
 rtl/tm_load_sequencer.sv | 162 ++++++++++++++++
 tb/tb_tm_load_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/tm_load_sequencer.sv
// Load/run sequencer for a small Turing machine core: loads program and tape memories from switch input, then runs the core.
// Optional step limit is enabled by defining TM_STEP_LIMIT_EN.
module tm_load_sequencer #(
  parameter int DATA_W    = 6,
  parameter int DEPTH     = 64,
  parameter int MAX_STEPS = 4096,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] input_data,
  input  logic              next,
  input  logic              done,
  input  logic              tm_halted,
  output logic              wr_en,
  output logic              wr_sel,
  output logic [AW-1:0]     wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              tm_start,
  output logic              tm_step_en,
  output logic [1:0]        phase,
  output logic              compute_done,
  output logic              error
);

  typedef enum logic [1:0] {
    PROG = 2'b00,
    TAPE = 2'b01,
    RUN  = 2'b10,
    HALT = 2'b11
  } state_t;

  state_t state_reg, state_next;

  logic              next_prev_reg, done_prev_reg;
  logic              next_ev, done_ev;
  logic [AW:0]       count_reg, count_next;
  logic              wr_en_reg, wr_en_next;
  logic              wr_sel_reg, wr_sel_next;
  logic [AW-1:0]     wr_addr_reg, wr_addr_next;
  logic [DATA_W-1:0] wr_data_reg, wr_data_next;
  logic              tm_start_reg, tm_start_next;
  logic              step_en_reg, step_en_next;
  logic              compute_done_reg, compute_done_next;
  logic              error_reg, error_next;
  logic              limit_hit;

  assign next_ev = next & ~next_prev_reg;
  assign done_ev = done & ~done_prev_reg;

`ifdef TM_STEP_LIMIT_EN
  localparam int SW = $clog2(MAX_STEPS + 1);
  logic [SW-1:0] step_cnt_reg;

  // Limit fires on the cycle carrying the MAX_STEPS-th step enable.
  assign limit_hit = step_en_reg && (step_cnt_reg == SW'(MAX_STEPS - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      step_cnt_reg <= '0;
    end else if (state_reg != RUN) begin
      step_cnt_reg <= '0;
    end else if (step_en_reg) begin
      step_cnt_reg <= step_cnt_reg + 1'b1;
    end
  end
`else
  logic [31:0] unused_max_steps;
  assign unused_max_steps = MAX_STEPS;
  assign limit_hit        = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= PROG;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      PROG: if (done_ev) state_next = TAPE;
      TAPE: if (done_ev) state_next = RUN;
      RUN:  if (tm_halted || limit_hit) state_next = HALT;
      HALT: if (done_ev) state_next = PROG;
      default: state_next = PROG;
    endcase
  end

  always_comb begin
    wr_en_next        = 1'b0;
    wr_sel_next       = wr_sel_reg;
    wr_addr_next      = wr_addr_reg;
    wr_data_next      = wr_data_reg;
    count_next        = count_reg;
    error_next        = error_reg;
    tm_start_next     = (state_reg == TAPE) && (state_next == RUN);
    step_en_next      = (state_reg == RUN) && (state_next == RUN);
    compute_done_next = (state_next == HALT);

    // A coincident Done takes priority, so the Next is dropped entirely.
    if ((state_reg == PROG || state_reg == TAPE) && next_ev && !done_ev) begin
      if (count_reg == (AW+1)'(DEPTH)) begin
        error_next = 1'b1;
      end else begin
        wr_en_next   = 1'b1;
        wr_sel_next  = (state_reg == TAPE);
        wr_addr_next = count_reg[AW-1:0];
        wr_data_next = input_data;
        count_next   = count_reg + 1'b1;
      end
    end

    if (state_next != state_reg && (state_next == TAPE || state_next == PROG))
      count_next = '0;

    if (state_reg == RUN && limit_hit && !tm_halted)
      error_next = 1'b1;

    if (state_reg == HALT && done_ev)
      error_next = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // Held buttons look already-high so releasing reset creates no edge.
      next_prev_reg    <= 1'b1;
      done_prev_reg    <= 1'b1;
      count_reg        <= '0;
      wr_en_reg        <= 1'b0;
      wr_sel_reg       <= 1'b0;
      wr_addr_reg      <= '0;
      wr_data_reg      <= '0;
      tm_start_reg     <= 1'b0;
      step_en_reg      <= 1'b0;
      compute_done_reg <= 1'b0;
      error_reg        <= 1'b0;
    end else begin
      next_prev_reg    <= next;
      done_prev_reg    <= done;
      count_reg        <= count_next;
      wr_en_reg        <= wr_en_next;
      wr_sel_reg       <= wr_sel_next;
      wr_addr_reg      <= wr_addr_next;
      wr_data_reg      <= wr_data_next;
      tm_start_reg     <= tm_start_next;
      step_en_reg      <= step_en_next;
      compute_done_reg <= compute_done_next;
      error_reg        <= error_next;
    end
  end

  assign wr_en        = wr_en_reg;
  assign wr_sel       = wr_sel_reg;
  assign wr_addr      = wr_addr_reg;
  assign wr_data      = wr_data_reg;
  assign tm_start     = tm_start_reg;
  assign tm_step_en   = step_en_reg;
  assign phase        = state_reg;
  assign compute_done = compute_done_reg;
  assign error        = error_reg;

endmodule

// File: tb/tb_tm_load_sequencer.sv
// Directed bench for tm_load_sequencer: load, run, halt, overflow, reset abort and step-limit scenarios.
module tb_tm_load_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] input_data = '0;
  logic       next = 1'b1;
  logic       done = 1'b0;
  logic       tm_halted = 1'b0;
  logic       wr_en, wr_sel, tm_start, tm_step_en, compute_done, error;
  logic [5:0] wr_addr;
  logic [5:0] wr_data;
  logic [1:0] phase;

  int checks = 0;
  int failures = 0;

`ifdef TM_STEP_LIMIT_EN
  localparam int RUN_STEPS = 5;
`else
  localparam int RUN_STEPS = 10;
`endif

  tm_load_sequencer #(.DATA_W(6), .DEPTH(64), .MAX_STEPS(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .input_data   (input_data),
    .next         (next),
    .done         (done),
    .tm_halted    (tm_halted),
    .wr_en        (wr_en),
    .wr_sel       (wr_sel),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .tm_start     (tm_start),
    .tm_step_en   (tm_step_en),
    .phase        (phase),
    .compute_done (compute_done),
    .error        (error)
  );

  always #5 clock = ~clock;

  task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic press_next(input logic [5:0] d, input logic exp_wr, input logic [5:0] exp_addr, input logic exp_sel);
    input_data = d;
    next = 1'b1;
    tick();
    $display("next   data=0x%02h wr_en=%0b addr=%0d sel=%0b phase=%0d", d, wr_en, wr_addr, wr_sel, phase);
    check_value("wr_en_after_next", {31'd0, wr_en}, {31'd0, exp_wr});
    if (exp_wr) begin
      check_value("wr_addr", {26'd0, wr_addr}, {26'd0, exp_addr});
      check_value("wr_data", {26'd0, wr_data}, {26'd0, d});
      check_value("wr_sel", {31'd0, wr_sel}, {31'd0, exp_sel});
    end
    next = 1'b0;
    tick();
    check_value("wr_en_one_cycle", {31'd0, wr_en}, 32'd0);
  endtask

  task automatic done_edge();
    done = 1'b1;
    tick();
    done = 1'b0;
    $display("done   phase=%0d tm_start=%0b error=%0b", phase, tm_start, error);
  endtask

  initial begin
    // Reset with Next held high across release
    tick();
    tick();
    check_value("rst_phase", {30'd0, phase}, 32'd0);
    check_value("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check_value("rst_error", {31'd0, error}, 32'd0);
    check_value("rst_step_en", {31'd0, tm_step_en}, 32'd0);
    check_value("rst_compute_done", {31'd0, compute_done}, 32'd0);
    reset = 1'b0;
    tick();
    check_value("held_next_wr_en_a", {31'd0, wr_en}, 32'd0);
    tick();
    check_value("held_next_wr_en_b", {31'd0, wr_en}, 32'd0);
    check_value("held_next_phase", {30'd0, phase}, 32'd0);
    next = 1'b0;
    tick();

    // Reset mid-write aborts the strobe immediately
    input_data = 6'h15;
    next = 1'b1;
    tick();
    check_value("abort_pre_wr_en", {31'd0, wr_en}, 32'd1);
    reset = 1'b1;
    #1;
    check_value("abort_wr_en", {31'd0, wr_en}, 32'd0);
    next = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // Program load
    press_next(6'h05, 1'b1, 6'd0, 1'b0);
    press_next(6'h2A, 1'b1, 6'd1, 1'b0);
    press_next(6'h3F, 1'b1, 6'd2, 1'b0);

    // Tape load
    done_edge();
    check_value("tape_phase", {30'd0, phase}, 32'd1);
    tick();
    press_next(6'h11, 1'b1, 6'd0, 1'b1);
    press_next(6'h22, 1'b1, 6'd1, 1'b1);

    // Run
    done_edge();
    check_value("run_phase", {30'd0, phase}, 32'd2);
    check_value("run_start", {31'd0, tm_start}, 32'd1);
    check_value("run_first_step_en", {31'd0, tm_step_en}, 32'd0);
    tick();
    check_value("run_start_one_cycle", {31'd0, tm_start}, 32'd0);
    check_value("run_step_en_1", {31'd0, tm_step_en}, 32'd1);
    for (int i = 2; i <= RUN_STEPS; i++) begin
      if (i == 3) begin
        next = 1'b1;
        done = 1'b1;
      end
      if (i == 4) begin
        next = 1'b0;
        done = 1'b0;
      end
      tick();
      check_value("run_step_en", {31'd0, tm_step_en}, 32'd1);
      check_value("run_ignore_wr_en", {31'd0, wr_en}, 32'd0);
    end
    check_value("run_ignore_done_phase", {30'd0, phase}, 32'd2);
    tm_halted = 1'b1;
    tick();
    tm_halted = 1'b0;
    $display("halt   phase=%0d compute_done=%0b step_en=%0b", phase, compute_done, tm_step_en);
    check_value("halt_phase", {30'd0, phase}, 32'd3);
    check_value("halt_compute_done", {31'd0, compute_done}, 32'd1);
    check_value("halt_step_en", {31'd0, tm_step_en}, 32'd0);
    check_value("halt_error", {31'd0, error}, 32'd0);
    tick();
    check_value("halt_stays", {30'd0, phase}, 32'd3);
    press_next(6'h01, 1'b0, 6'd0, 1'b0);
    done_edge();
    check_value("back_prog_phase", {30'd0, phase}, 32'd0);
    check_value("back_prog_error", {31'd0, error}, 32'd0);
    check_value("back_prog_compute_done", {31'd0, compute_done}, 32'd0);
    tick();

    // Overflow: 64 writes then a rejected 65th
    for (int i = 0; i < 64; i++) begin
      press_next(6'(i ^ 21), 1'b1, 6'(i), 1'b0);
    end
    check_value("pre_overflow_error", {31'd0, error}, 32'd0);
    press_next(6'h3C, 1'b0, 6'd0, 1'b0);
    check_value("overflow_error", {31'd0, error}, 32'd1);

    // Next and Done on the same edge: Done wins
    next = 1'b1;
    done = 1'b1;
    tick();
    $display("both   phase=%0d wr_en=%0b", phase, wr_en);
    check_value("both_phase", {30'd0, phase}, 32'd1);
    check_value("both_wr_en", {31'd0, wr_en}, 32'd0);
    next = 1'b0;
    done = 1'b0;
    tick();
    check_value("both_wr_en_later", {31'd0, wr_en}, 32'd0);

    // Reset mid-RUN
    done_edge();
    check_value("run2_phase", {30'd0, phase}, 32'd2);
    tick();
    tick();
    check_value("run2_step_en", {31'd0, tm_step_en}, 32'd1);
    reset = 1'b1;
    #1;
    $display("reset  phase=%0d step_en=%0b error=%0b", phase, tm_step_en, error);
    check_value("run_abort_step_en", {31'd0, tm_step_en}, 32'd0);
    check_value("run_abort_phase", {30'd0, phase}, 32'd0);
    check_value("run_abort_error", {31'd0, error}, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Step limit (or unbounded run without the limit)
    done_edge();
    check_value("lim_tape_phase", {30'd0, phase}, 32'd1);
    tick();
    done_edge();
    check_value("lim_run_start", {31'd0, tm_start}, 32'd1);
`ifdef TM_STEP_LIMIT_EN
    for (int i = 1; i <= 8; i++) begin
      tick();
      check_value("lim_step_en", {31'd0, tm_step_en}, 32'd1);
      check_value("lim_phase_run", {30'd0, phase}, 32'd2);
    end
    tick();
    $display("limit  phase=%0d error=%0b compute_done=%0b", phase, error, compute_done);
    check_value("lim_phase_halt", {30'd0, phase}, 32'd3);
    check_value("lim_error", {31'd0, error}, 32'd1);
    check_value("lim_compute_done", {31'd0, compute_done}, 32'd1);
    check_value("lim_step_en_off", {31'd0, tm_step_en}, 32'd0);
`else
    repeat (100) tick();
    $display("nolim  phase=%0d step_en=%0b error=%0b", phase, tm_step_en, error);
    check_value("nolim_phase", {30'd0, phase}, 32'd2);
    check_value("nolim_step_en", {31'd0, tm_step_en}, 32'd1);
    check_value("nolim_error", {31'd0, error}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
